// File: rtl/i2c_byte_master_pkg.sv
// i2c_byte_master_pkg: shared command encodings, FSM states and decode helper
package i2c_byte_master_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WR,
        S_RD,
        S_STOP,
        S_RESP
    } state_e;

    function automatic state_e cmd_state(cmd_e c);
        return c == CMD_START ? S_START : c == CMD_WRITE ? S_WR : c == CMD_READ ? S_RD : S_STOP;
    endfunction

endpackage

// File: rtl/i2c_byte_master_if.sv
// i2c_byte_master_if: command/response handshake plus SCL/SDA pad signals
interface i2c_byte_master_if;
    import i2c_byte_master_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    cmd_e       cmd;
    logic [7:0] wdata;
    logic       mack;
    logic       rsp_valid;
    logic [7:0] rdata;
    logic       ack_n;
    logic       err;
    logic       busy;
    logic       scl_o;
    logic       sda_out;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        output cmd_valid, cmd, wdata, mack, sda_i,
        input  cmd_ready, rsp_valid, rdata, ack_n, err, busy, scl_o, sda_out, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd, wdata, mack, sda_i,
        output cmd_ready, rsp_valid, rdata, ack_n, err, busy, scl_o, sda_out, sda_oe
    );

endinterface

// File: rtl/i2c_byte_master_qtick.sv
// i2c_byte_master_qtick: quarter-SCL-period tick generator
module i2c_byte_master_qtick #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic qtick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] TC = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign qtick = en && cnt == TC;

    // count clk cycles within one quarter period, wrapping at the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr || qtick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master engine (START/WRITE/READ/STOP)
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input logic               clk,
    input logic               rst_n,
    i2c_byte_master_if.slave  bus
);
    state_e     state, state_n;
    logic [1:0] phase, phase_n;
    logic [3:0] bitc, bit_n;
    logic       held, held_n;
    logic [7:0] wbyte, wbyte_n;
    logic       mack_q, mack_n;
    logic       scl_n, oe_n, out_n;
    logic       qtick, accept, last;

    assign accept        = bus.cmd_valid && state == S_IDLE;
    assign last          = qtick && phase == 2'd3 && (state == S_START || state == S_STOP || bitc == 4'd8);
    assign bus.cmd_ready = state == S_IDLE;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.busy      = state != S_IDLE;

    i2c_byte_master_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.busy),
        .clr   (accept),
        .qtick (qtick)
    );

    // next state, slot/phase counters and the pin levels for the coming cycle
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bitc;
        held_n  = held;
        wbyte_n = wbyte;
        mack_n  = mack_q;
        if (accept) begin
            state_n = (bus.cmd != CMD_START && !held) ? S_RESP : cmd_state(bus.cmd);
            phase_n = '0;
            bit_n   = '0;
            wbyte_n = bus.wdata;
            mack_n  = bus.mack;
        end else if (state == S_RESP) begin
            state_n = S_IDLE;
        end else if (qtick) begin
            phase_n = phase + 2'd1;
            bit_n   = (phase == 2'd3 && bitc != 4'd8) ? bitc + 4'd1 : bitc;
            state_n = last ? S_RESP : state;
            held_n  = last ? (state == S_START) || (held && state != S_STOP) : held;
        end
        scl_n = 1'b1;
        oe_n  = 1'b0;
        out_n = 1'b1;
        case (state_n)
            S_START: begin
                scl_n = phase_n[0] ^ phase_n[1];
                oe_n  = phase_n[1];
                out_n = !phase_n[1];
            end
            S_WR: begin
                scl_n = phase_n[0] ^ phase_n[1];
                oe_n  = !bit_n[3];
                out_n = bit_n[3] | wbyte_n[~bit_n[2:0]];
            end
            S_RD: begin
                scl_n = phase_n[0] ^ phase_n[1];
                oe_n  = bit_n[3] && mack_n;
                out_n = !(bit_n[3] && mack_n);
            end
            S_STOP: begin
                scl_n = phase_n != 2'd0;
                oe_n  = !phase_n[1];
                out_n = phase_n[1];
            end
            default: begin
                scl_n = !held_n;
                oe_n  = held_n;
                out_n = !held_n;
            end
        endcase
    end

    // FSM state, counters and glitch-free registered pin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            phase       <= '0;
            bitc        <= '0;
            held        <= 1'b0;
            wbyte       <= '0;
            mack_q      <= 1'b0;
            bus.scl_o   <= 1'b1;
            bus.sda_oe  <= 1'b0;
            bus.sda_out <= 1'b1;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            bitc        <= bit_n;
            held        <= held_n;
            wbyte       <= wbyte_n;
            mack_q      <= mack_n;
            bus.scl_o   <= scl_n;
            bus.sda_oe  <= oe_n;
            bus.sda_out <= out_n;
        end
    end

    // response status at accept; SDA sampled at the end of the second SCL-high quarter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
            bus.ack_n <= 1'b0;
            bus.err   <= 1'b0;
        end else if (accept) begin
            bus.ack_n <= 1'b0;
            bus.err   <= bus.cmd != CMD_START && !held;
        end else if (qtick && phase == 2'd2) begin
            if (state == S_WR && bitc[3]) bus.ack_n <= bus.sda_i;
            if (state == S_RD && !bitc[3]) bus.rdata <= {bus.rdata[6:0], bus.sda_i};
        end
    end

endmodule
